// File: rtl/snitch_icache_pkg.sv
// Shared types and tag-word layout for the instruction cache tag controller.
package snitch_icache_pkg;

  // Controller states: power-up sweep, normal service, invalidate-all sweep.
  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StFlush
  } tag_state_e;

  // Stored tag word is {valid, error, tag}; these offsets sit above the tag bits.
  localparam int unsigned TagErrOff   = 0;
  localparam int unsigned TagValidOff = 1;

  function automatic int unsigned tag_valid_bit(input int unsigned tag_width);
    return tag_width + TagValidOff;
  endfunction

  function automatic int unsigned tag_err_bit(input int unsigned tag_width);
    return tag_width + TagErrOff;
  endfunction

endpackage

// File: rtl/snitch_icache_tag_cmp.sv
// Combinational tag compare across all ways: any-hit, lowest hitting way and its error bit.
module snitch_icache_tag_cmp
  import snitch_icache_pkg::*;
#(
  parameter int unsigned SET_COUNT = 2,
  parameter int unsigned TAG_WIDTH = 20,
  parameter int unsigned SET_W     = 1
) (
  input  logic [SET_COUNT-1:0][TAG_WIDTH+1:0] rtag,
  input  logic [TAG_WIDTH-1:0]                tag,
  output logic                                hit,
  output logic                                err,
  output logic [SET_W-1:0]                    set
);

  localparam int unsigned ValidBit = tag_valid_bit(TAG_WIDTH);
  localparam int unsigned ErrBit   = tag_err_bit(TAG_WIDTH);

  logic [SET_COUNT-1:0] way_hit;

  // Per-way match: entry must be valid and carry the requested tag.
  always_comb begin
    way_hit = '0;
    for (int i = 0; i < int'(SET_COUNT); i++) begin
      way_hit[i] = rtag[i][ValidBit] && (rtag[i][TAG_WIDTH-1:0] == tag);
    end
  end

  // Walk from the top way down so the lowest hitting way wins.
  always_comb begin
    hit = |way_hit;
    err = 1'b0;
    set = '0;
    for (int i = int'(SET_COUNT) - 1; i >= 0; i--) begin
      if (way_hit[i]) begin
        set = SET_W'(i);
        err = rtag[i][ErrBit];
      end
    end
  end

endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag SRAM controller: init/flush sweeps, refill writes and one-cycle-latency lookups.
module snitch_icache_tag_ctrl
  import snitch_icache_pkg::*;
#(
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned LINE_COUNT = 128,
  parameter int unsigned TAG_WIDTH  = 20,
  localparam int unsigned LINE_AW   = $clog2(LINE_COUNT),
  localparam int unsigned SET_W     = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_valid_i,
  output logic                                flush_ready_o,
  input  logic                                lookup_valid_i,
  output logic                                lookup_ready_o,
  input  logic [LINE_AW-1:0]                  lookup_addr_i,
  input  logic [TAG_WIDTH-1:0]                lookup_tag_i,
  output logic                                lookup_rsp_valid_o,
  output logic                                lookup_hit_o,
  output logic                                lookup_err_o,
  output logic [SET_W-1:0]                    lookup_set_o,
  input  logic                                refill_valid_i,
  output logic                                refill_ready_o,
  input  logic [LINE_AW-1:0]                  refill_addr_i,
  input  logic [SET_W-1:0]                    refill_set_i,
  input  logic [TAG_WIDTH-1:0]                refill_tag_i,
  input  logic                                refill_err_i,
  output logic [SET_COUNT-1:0]                ram_enable_o,
  output logic                                ram_write_o,
  output logic [LINE_AW-1:0]                  ram_addr_o,
  output logic [TAG_WIDTH+1:0]                ram_wtag_o,
  input  logic [SET_COUNT-1:0][TAG_WIDTH+1:0] ram_rtag_i
);

  localparam logic [LINE_AW-1:0] LastLine = LINE_AW'(LINE_COUNT - 1);

  tag_state_e           state_q;
  logic [LINE_AW-1:0]   cnt_q;
  logic                 rsp_valid_q;
  logic [TAG_WIDTH-1:0] tag_q;

  logic sweeping, idle, flush_xfer, refill_xfer, lookup_xfer;
  logic cmp_hit, cmp_err;
  logic [SET_W-1:0] cmp_set;

  assign sweeping    = (state_q == StInit) || (state_q == StFlush);
  assign idle        = (state_q == StIdle);
  assign flush_xfer  = idle && flush_valid_i;
  assign refill_xfer = idle && refill_valid_i && !flush_valid_i;
  assign lookup_xfer = idle && lookup_valid_i && !flush_valid_i && !refill_valid_i;

  // FSM, sweep counter and lookup response pipeline register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      rsp_valid_q <= lookup_xfer;
      if (lookup_xfer) tag_q <= lookup_tag_i;
      unique case (state_q)
        StInit, StFlush: begin
          // Counter wraps to zero on the last line, ready for the next sweep.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastLine) state_q <= StIdle;
        end
        StIdle: begin
          if (flush_xfer) begin
            cnt_q   <= '0;
            state_q <= StFlush;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Handshake readies and SRAM port drive; priority flush > refill > lookup.
  always_comb begin
    flush_ready_o  = idle;
    refill_ready_o = idle && !flush_valid_i;
    lookup_ready_o = idle && !flush_valid_i && !refill_valid_i;
    ram_enable_o   = '0;
    ram_write_o    = 1'b0;
    ram_addr_o     = '0;
    ram_wtag_o     = '0;
    if (sweeping) begin
      ram_enable_o = '1;
      ram_write_o  = 1'b1;
      ram_addr_o   = cnt_q;
    end else if (refill_xfer) begin
      ram_enable_o = SET_COUNT'(1) << refill_set_i;
      ram_write_o  = 1'b1;
      ram_addr_o   = refill_addr_i;
      ram_wtag_o   = {1'b1, refill_err_i, refill_tag_i};
    end else if (lookup_xfer) begin
      ram_enable_o = '1;
      ram_addr_o   = lookup_addr_i;
    end
  end

  snitch_icache_tag_cmp #(
    .SET_COUNT(SET_COUNT),
    .TAG_WIDTH(TAG_WIDTH),
    .SET_W    (SET_W)
  ) u_tag_cmp (
    .rtag(ram_rtag_i),
    .tag (tag_q),
    .hit (cmp_hit),
    .err (cmp_err),
    .set (cmp_set)
  );

  // Response fields are forced to zero whenever no response is presented.
  always_comb begin
    lookup_rsp_valid_o = rsp_valid_q;
    lookup_hit_o       = rsp_valid_q && cmp_hit;
    lookup_err_o       = rsp_valid_q && cmp_hit && cmp_err;
    lookup_set_o       = rsp_valid_q ? cmp_set : '0;
  end

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Directed bench for snitch_icache_tag_ctrl with a behavioural two-way tag SRAM.
module tb_snitch_icache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_valid_i, flush_ready_o;
  logic        lookup_valid_i, lookup_ready_o;
  logic [6:0]  lookup_addr_i;
  logic [19:0] lookup_tag_i;
  logic        lookup_rsp_valid_o, lookup_hit_o, lookup_err_o;
  logic        lookup_set_o;
  logic        refill_valid_i, refill_ready_o;
  logic [6:0]  refill_addr_i;
  logic        refill_set_i;
  logic [19:0] refill_tag_i;
  logic        refill_err_i;
  logic [1:0]  ram_enable_o;
  logic        ram_write_o;
  logic [6:0]  ram_addr_o;
  logic [21:0] ram_wtag_o;
  logic [1:0][21:0] ram_rtag_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snitch_icache_tag_ctrl #(
    .SET_COUNT (2),
    .LINE_COUNT(128),
    .TAG_WIDTH (20)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .flush_valid_i     (flush_valid_i),
    .flush_ready_o     (flush_ready_o),
    .lookup_valid_i    (lookup_valid_i),
    .lookup_ready_o    (lookup_ready_o),
    .lookup_addr_i     (lookup_addr_i),
    .lookup_tag_i      (lookup_tag_i),
    .lookup_rsp_valid_o(lookup_rsp_valid_o),
    .lookup_hit_o      (lookup_hit_o),
    .lookup_err_o      (lookup_err_o),
    .lookup_set_o      (lookup_set_o),
    .refill_valid_i    (refill_valid_i),
    .refill_ready_o    (refill_ready_o),
    .refill_addr_i     (refill_addr_i),
    .refill_set_i      (refill_set_i),
    .refill_tag_i      (refill_tag_i),
    .refill_err_i      (refill_err_i),
    .ram_enable_o      (ram_enable_o),
    .ram_write_o       (ram_write_o),
    .ram_addr_o        (ram_addr_o),
    .ram_wtag_o        (ram_wtag_o),
    .ram_rtag_i        (ram_rtag_i)
  );

  // Tag SRAM model: write or read per enabled way, read data one cycle later.
  logic [21:0] mem   [2][128];
  logic [21:0] rdata [2];
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (ram_enable_o[s]) begin
        if (ram_write_o) mem[s][ram_addr_o] <= ram_wtag_o;
        else             rdata[s] <= mem[s][ram_addr_o];
      end
    end
  end
  assign ram_rtag_i[0] = rdata[0];
  assign ram_rtag_i[1] = rdata[1];

  // One cycle of stimulus and its expected outputs; rsp is {valid, hit, err, set}.
  typedef struct {
    logic fv, rv, lv;
    logic [6:0] raddr; logic rset; logic [19:0] rtag; logic rerr;
    logic [6:0] laddr; logic [19:0] ltag;
    logic [2:0] rdy; logic [1:0] en; logic we; logic [6:0] addr; logic [21:0] wtag;
    logic [3:0] rsp;
  } vec_t;

  function automatic vec_t mkv(input logic fv, rv, lv, input logic [6:0] raddr,
                               input logic rset, input logic [19:0] rtag, input logic rerr,
                               input logic [6:0] laddr, input logic [19:0] ltag,
                               input logic [2:0] rdy, input logic [1:0] en, input logic we,
                               input logic [6:0] addr, input logic [21:0] wtag,
                               input logic [3:0] rsp);
    vec_t v;
    v.fv = fv; v.rv = rv; v.lv = lv;
    v.raddr = raddr; v.rset = rset; v.rtag = rtag; v.rerr = rerr;
    v.laddr = laddr; v.ltag = ltag;
    v.rdy = rdy; v.en = en; v.we = we; v.addr = addr; v.wtag = wtag; v.rsp = rsp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    flush_valid_i  = v.fv;
    refill_valid_i = v.rv;
    lookup_valid_i = v.lv;
    refill_addr_i  = v.raddr;
    refill_set_i   = v.rset;
    refill_tag_i   = v.rtag;
    refill_err_i   = v.rerr;
    lookup_addr_i  = v.laddr;
    lookup_tag_i   = v.ltag;
    #1;
    check({name, "/rdy"}, 64'({flush_ready_o, refill_ready_o, lookup_ready_o}), 64'(v.rdy));
    check({name, "/ram"}, 64'({ram_enable_o, ram_write_o, ram_addr_o, ram_wtag_o}),
          64'({v.en, v.we, v.addr, v.wtag}));
    check({name, "/rsp"}, 64'({lookup_rsp_valid_o, lookup_hit_o, lookup_err_o, lookup_set_o}),
          64'(v.rsp));
  endtask

  // Expect n consecutive sweep cycles starting at line 0: all ways written with zero.
  task automatic sweep(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      flush_valid_i = 1'b0;
      #1;
      check($sformatf("%s/line%0d", name, c),
            64'({flush_ready_o, refill_ready_o, lookup_ready_o,
                 lookup_rsp_valid_o, lookup_hit_o, lookup_err_o, lookup_set_o,
                 ram_write_o, ram_enable_o, ram_addr_o, ram_wtag_o}),
            64'({3'b000, 4'b0000, 1'b1, 2'b11, 7'(c), 22'h0}));
    end
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,     3'b111,2'b00,0,7'd0,22'h0,4'b0000);
    vecs[1]  = mkv(0,1,0, 7'd5,1,20'hABCDE,0, 7'd0,20'h0, 3'b110,2'b10,1,7'd5,22'h2ABCDE,4'b0000);
    vecs[2]  = mkv(0,0,1, 7'd0,0,20'h0,0, 7'd5,20'hABCDE, 3'b111,2'b11,0,7'd5,22'h0,4'b0000);
    vecs[3]  = mkv(0,0,1, 7'd0,0,20'h0,0, 7'd5,20'hABCDF, 3'b111,2'b11,0,7'd5,22'h0,4'b1101);
    vecs[4]  = mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,     3'b111,2'b00,0,7'd0,22'h0,4'b1000);
    vecs[5]  = mkv(0,1,0, 7'd9,0,20'h12345,0, 7'd0,20'h0, 3'b110,2'b01,1,7'd9,22'h212345,4'b0000);
    vecs[6]  = mkv(0,1,0, 7'd9,1,20'h12345,0, 7'd0,20'h0, 3'b110,2'b10,1,7'd9,22'h212345,4'b0000);
    vecs[7]  = mkv(0,0,1, 7'd0,0,20'h0,0, 7'd9,20'h12345, 3'b111,2'b11,0,7'd9,22'h0,4'b0000);
    vecs[8]  = mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,     3'b111,2'b00,0,7'd0,22'h0,4'b1100);
    vecs[9]  = mkv(0,1,0, 7'd20,0,20'h00777,1, 7'd0,20'h0, 3'b110,2'b01,1,7'd20,22'h300777,4'b0000);
    vecs[10] = mkv(0,0,1, 7'd0,0,20'h0,0, 7'd20,20'h00777, 3'b111,2'b11,0,7'd20,22'h0,4'b0000);
    vecs[11] = mkv(0,0,1, 7'd0,0,20'h0,0, 7'd100,20'h0,   3'b111,2'b11,0,7'd100,22'h0,4'b1110);
    vecs[12] = mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,     3'b111,2'b00,0,7'd0,22'h0,4'b1000);
    vecs[13] = mkv(0,1,1, 7'd40,1,20'h0BEEF,0, 7'd40,20'h0BEEF,
                   3'b110,2'b10,1,7'd40,22'h20BEEF,4'b0000);
    vecs[14] = mkv(0,0,1, 7'd0,0,20'h0,0, 7'd40,20'h0BEEF, 3'b111,2'b11,0,7'd40,22'h0,4'b0000);
    vecs[15] = mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,     3'b111,2'b00,0,7'd0,22'h0,4'b1101);

    rst_ni = 1'b0;
    flush_valid_i = 0; refill_valid_i = 0; lookup_valid_i = 0;
    refill_addr_i = '0; refill_set_i = 0; refill_tag_i = '0; refill_err_i = 0;
    lookup_addr_i = '0; lookup_tag_i = '0;
    repeat (2) @(posedge clk);
    pulse_reset();

    // Power-up sweep, then the directed table (first entry is cycle 129).
    sweep(128, "init");
    for (int i = 0; i < 16; i++) step(vecs[i], $sformatf("vec%0d", i));

    // All three requesters at once: only the flush is taken; held requests drain after.
    step(mkv(1,1,1, 7'd30,1,20'h55555,0, 7'd20,20'h00777,
             3'b100,2'b00,0,7'd0,22'h0,4'b0000), "flush_prio");
    sweep(128, "flush");
    step(mkv(0,1,1, 7'd30,1,20'h55555,0, 7'd20,20'h00777,
             3'b110,2'b10,1,7'd30,22'h255555,4'b0000), "post_refill");
    step(mkv(0,0,1, 7'd0,0,20'h0,0, 7'd20,20'h00777,
             3'b111,2'b11,0,7'd20,22'h0,4'b0000), "post_lookup");
    step(mkv(0,0,1, 7'd0,0,20'h0,0, 7'd30,20'h55555,
             3'b111,2'b11,0,7'd30,22'h0,4'b1000), "flushed_miss");
    step(mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,
             3'b111,2'b00,0,7'd0,22'h0,4'b1101), "refill_hit");

    // Reset on the cycle a lookup is accepted: no response, full INIT sweep.
    @(negedge clk);
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd5; lookup_tag_i = 20'hABCDE;
    @(posedge clk);
    lookup_valid_i = 1'b0;
    pulse_reset();
    sweep(128, "rst_lookup");
    step(mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,
             3'b111,2'b00,0,7'd0,22'h0,4'b0000), "rst_lookup_idle");

    // Reset at sweep line 60 of a flush: sweep restarts from line 0.
    step(mkv(1,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,
             3'b100,2'b00,0,7'd0,22'h0,4'b0000), "flush2");
    sweep(61, "flush2");
    pulse_reset();
    sweep(128, "rst_sweep");
    step(mkv(0,0,0, 7'd0,0,20'h0,0, 7'd0,20'h0,
             3'b111,2'b00,0,7'd0,22'h0,4'b0000), "rst_sweep_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
